// File: rtl/wbwcombine_if.sv
// Wishbone bus bundle for the wide write combiner: upstream slave side, downstream master side, FSM debug state.
// The DUT connects through the slave modport; the environment drives through the master modport.
interface wbwcombine_if #(
    parameter int AW = 22,
    parameter int DW = 512
);
    logic              i_scyc;
    logic              i_sstb;
    logic              i_swe;
    logic [AW-1:0]     i_saddr;
    logic [DW-1:0]     i_sdata;
    logic [DW/8-1:0]   i_ssel;
    logic              o_sstall;
    logic              o_sack;
    logic [DW-1:0]     o_sdata;
    logic              o_serr;
    logic              o_mcyc;
    logic              o_mstb;
    logic              o_mwe;
    logic [AW-1:0]     o_maddr;
    logic [DW-1:0]     o_mdata;
    logic [DW/8-1:0]   o_msel;
    logic              i_mstall;
    logic              i_mack;
    logic              i_merr;
    logic [DW-1:0]     i_mdata;
    logic              o_werr;
    logic [1:0]        dbg_state;

    modport slave (
        input  i_scyc, i_sstb, i_swe, i_saddr, i_sdata, i_ssel,
        output o_sstall, o_sack, o_sdata, o_serr,
        output o_mcyc, o_mstb, o_mwe, o_maddr, o_mdata, o_msel,
        input  i_mstall, i_mack, i_merr, i_mdata,
        output o_werr, dbg_state
    );

    modport master (
        output i_scyc, i_sstb, i_swe, i_saddr, i_sdata, i_ssel,
        input  o_sstall, o_sack, o_sdata, o_serr,
        input  o_mcyc, o_mstb, o_mwe, o_maddr, o_mdata, o_msel,
        output i_mstall, i_mack, i_merr, i_mdata,
        input  o_werr, dbg_state
    );
endinterface

// File: rtl/wbwcombine.sv
// Wide-bus Wishbone write combiner: merges partial writes to one wide word, posts them, flushes before reads.
// Optional WBWCOMBINE_FULLFLUSH_EN: a buffer whose byte selects become all ones is flushed without waiting.
//
// Handshake: an upstream request (i_scyc & i_sstb) is accepted on a rising edge where o_sstall is low;
// a downstream request (o_mstb) is accepted on a rising edge where i_mstall is low, and completes on i_mack/i_merr.
module wbwcombine #(
    parameter int ADDRESS_WIDTH = 28,
    parameter int DW            = 512,
    parameter int TIMEOUT       = 15,
    parameter bit OPT_LOWPOWER  = 1'b0,
    localparam int AW           = ADDRESS_WIDTH - $clog2(DW/8)
) (
    input logic         i_clk,
    input logic         i_reset,
    wbwcombine_if.slave bus
);
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2,
        RD    = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [AW-1:0]   buf_addr;
    logic [DW-1:0]   buf_data;
    logic [SW-1:0]   buf_sel;
    logic [7:0]      timer;
    logic [DW-1:0]   merged;
    logic            req, merge, stall, full_word, rd_done, wr_accept;

    assign req   = bus.i_scyc && bus.i_sstb;
    assign merge = (state == HOLD) && req && bus.i_swe && (bus.i_saddr == buf_addr);

`ifdef WBWCOMBINE_FULLFLUSH_EN
    assign full_word = &buf_sel;
`else
    assign full_word = 1'b0;
`endif

    always_comb begin
        merged = buf_data;
        for (int b = 0; b < SW; b++) begin
            if (bus.i_ssel[b]) merged[8*b +: 8] = bus.i_sdata[8*b +: 8];
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_next = bus.i_swe ? HOLD : RD;
            end
            HOLD: begin
                // A matching write wins over every flush cause, including a timer expiring this cycle.
                if (merge) begin
                    state_next = HOLD;
                end else if (req) begin
                    stall      = 1'b1;
                    state_next = FLUSH;
                end else if (full_word || !bus.i_scyc || timer == 8'(TIMEOUT)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                stall = 1'b1;
                if (bus.i_mack || bus.i_merr) state_next = IDLE;
            end
            RD: begin
                stall = 1'b1;
                if (!bus.i_scyc || bus.i_mack || bus.i_merr) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.o_sstall = stall;
    assign bus.dbg_state = state;
    assign wr_accept = req && bus.i_swe && !stall && (state == IDLE || state == HOLD);
    assign rd_done   = (state == RD) && bus.i_scyc && (bus.i_mack || bus.i_merr);

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            buf_addr    <= '0;
            buf_data    <= '0;
            buf_sel     <= '0;
            timer       <= '0;
            bus.o_sack  <= 1'b0;
            bus.o_serr  <= 1'b0;
            bus.o_sdata <= '0;
            bus.o_werr  <= 1'b0;
            bus.o_mcyc  <= 1'b0;
            bus.o_mstb  <= 1'b0;
            bus.o_mwe   <= 1'b0;
            bus.o_maddr <= '0;
            bus.o_mdata <= '0;
            bus.o_msel  <= '0;
        end else begin
            bus.o_sack <= wr_accept || (rd_done && bus.i_mack && !bus.i_merr);
            bus.o_serr <= rd_done && bus.i_merr;
            bus.o_werr <= (state == FLUSH) && bus.i_merr;
            if (rd_done)           bus.o_sdata <= bus.i_mdata;
            else if (OPT_LOWPOWER) bus.o_sdata <= '0;

            case (state)
                IDLE: begin
                    if (req && bus.i_swe) begin
                        buf_addr <= bus.i_saddr;
                        buf_data <= bus.i_sdata;
                        buf_sel  <= bus.i_ssel;
                        timer    <= '0;
                    end else if (req) begin
                        bus.o_mcyc  <= 1'b1;
                        bus.o_mstb  <= 1'b1;
                        bus.o_mwe   <= 1'b0;
                        bus.o_maddr <= bus.i_saddr;
                        bus.o_msel  <= bus.i_ssel;
                        if (OPT_LOWPOWER) bus.o_mdata <= '0;
                    end
                end
                HOLD: begin
                    if (merge) begin
                        buf_data <= merged;
                        buf_sel  <= buf_sel | bus.i_ssel;
                        timer    <= '0;
                    end else if (state_next == FLUSH) begin
                        bus.o_mcyc  <= 1'b1;
                        bus.o_mstb  <= 1'b1;
                        bus.o_mwe   <= 1'b1;
                        bus.o_maddr <= buf_addr;
                        bus.o_mdata <= buf_data;
                        bus.o_msel  <= buf_sel;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                FLUSH: begin
                    // The flush runs to completion even if the upstream cycle is dropped.
                    if (!bus.i_mstall) bus.o_mstb <= 1'b0;
                    if (bus.i_mack || bus.i_merr) begin
                        bus.o_mcyc <= 1'b0;
                        bus.o_mstb <= 1'b0;
                        bus.o_mwe  <= 1'b0;
                        buf_sel    <= '0;
                        if (OPT_LOWPOWER) begin
                            bus.o_mdata <= '0;
                            bus.o_msel  <= '0;
                        end
                    end
                end
                RD: begin
                    if (!bus.i_scyc || bus.i_mack || bus.i_merr) begin
                        bus.o_mcyc <= 1'b0;
                        bus.o_mstb <= 1'b0;
                        if (OPT_LOWPOWER) bus.o_msel <= '0;
                    end else if (!bus.i_mstall) begin
                        bus.o_mstb <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wbwcombine.sv
// Directed bench for wbwcombine: upstream driver tasks, a downstream responder, and queue-based scoreboards.
module tb_wbwcombine;
    localparam int ADDRESS_WIDTH = 16;
    localparam int DW            = 64;
    localparam int SW            = DW / 8;
    localparam int AW            = ADDRESS_WIDTH - $clog2(SW);
    localparam int TIMEOUT       = 15;
    localparam int MW            = 1 + AW + DW + SW;
    localparam int UW            = 2 + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wbwcombine_if #(.AW(AW), .DW(DW)) bus ();

    wbwcombine #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DW(DW),
        .TIMEOUT(TIMEOUT),
        .OPT_LOWPOWER(1'b0)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [UW-1:0] exp_s_q[$];
    logic [MW-1:0] exp_m_q[$];
    int  stall_cfg = 0;
    bit  err_cfg = 1'b0;
    int  werr_pulses = 0;
    int  werr_run = 0;
    int  werr_maxrun = 0;
    int  m_txn = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_s(input bit is_rd, input bit err, input logic [DW-1:0] d);
        exp_s_q.push_back({is_rd, err, d});
    endtask

    task automatic push_m(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        exp_m_q.push_back({we, a, d, s});
    endtask

    // Downstream responder and downstream scoreboard.
    initial begin
        bit pending = 1'b0;
        bit pend_err = 1'b0;
        bit stb_seen = 1'b0;
        int stall_left = 0;
        logic [MW-1:0] e;
        bus.i_mstall = 1'b0;
        bus.i_mack   = 1'b0;
        bus.i_merr   = 1'b0;
        bus.i_mdata  = '0;
        forever begin
            @(negedge clk);
            bus.i_mack   = 1'b0;
            bus.i_merr   = 1'b0;
            bus.i_mstall = 1'b0;
            if (pending && bus.o_mcyc) begin
                if (pend_err) bus.i_merr = 1'b1;
                else          bus.i_mack = 1'b1;
            end
            pending = 1'b0;
            if (rst || !bus.o_mstb) begin
                stb_seen = 1'b0;
            end else begin
                if (!stb_seen) begin
                    stb_seen = 1'b1;
                    stall_left = stall_cfg;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    bus.i_mstall = 1'b1;
                end else begin
                    pending  = 1'b1;
                    pend_err = err_cfg;
                    err_cfg  = 1'b0;
                    stb_seen = 1'b0;
                    m_txn++;
                    bus.i_mdata = {32'hDA7A_0000, 32'(bus.o_maddr)};
                    if (exp_m_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL down_unexpected: got we=%0d addr=%0h expected no transaction", bus.o_mwe, bus.o_maddr);
                    end else begin
                        e = exp_m_q.pop_front();
                        check("down_we", 64'(bus.o_mwe), 64'(e[MW-1]));
                        check("down_addr", 64'(bus.o_maddr), 64'(e[SW+DW +: AW]));
                        if (e[MW-1]) begin
                            check("down_data", 64'(bus.o_mdata), 64'(e[SW +: DW]));
                            check("down_sel", 64'(bus.o_msel), 64'(e[SW-1:0]));
                        end
                    end
                end
            end
        end
    end

    // Upstream monitor and scoreboard.
    initial begin
        logic [UW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_werr) begin
                if (werr_run == 0) werr_pulses++;
                werr_run++;
                if (werr_run > werr_maxrun) werr_maxrun = werr_run;
            end else begin
                werr_run = 0;
            end
            if (bus.o_sack || bus.o_serr) begin
                if (exp_s_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL up_unexpected: got ack=%0d err=%0d expected none", bus.o_sack, bus.o_serr);
                end else begin
                    e = exp_s_q.pop_front();
                    check("up_err", 64'(bus.o_serr), 64'(e[DW]));
                    check("up_ack", 64'(bus.o_sack), 64'(!e[DW]));
                    if (e[DW+1] && !e[DW]) begin
                        check("rd_data", 64'(bus.o_sdata), 64'(e[DW-1:0]));
                        check("rd_ack_after_mack", 64'(bus.i_mack), 64'd1);
                    end
                end
            end
        end
    end

    task automatic wb_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, output int stalls);
        stalls = 0;
        @(negedge clk);
        bus.i_scyc  = 1'b1;
        bus.i_sstb  = 1'b1;
        bus.i_swe   = we;
        bus.i_saddr = a;
        bus.i_sdata = d;
        bus.i_ssel  = s;
        forever begin
            #1;
            if (!bus.o_sstall) begin
                @(posedge clk);
                break;
            end
            stalls++;
            if (stalls > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got stall for %0d cycles expected acceptance", stalls);
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wb_idle();
        @(negedge clk);
        bus.i_sstb = 1'b0;
    endtask

    task automatic wb_release();
        @(negedge clk);
        bus.i_sstb = 1'b0;
        bus.i_scyc = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int k = 0;
        while (!(bus.dbg_state == 2'd0 && !bus.o_mcyc && exp_m_q.size() == 0 && exp_s_q.size() == 0)
               && k < max_cycles) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (k >= max_cycles) begin
            bad++;
            $display("FAIL %s: got busy after %0d cycles expected idle with empty queues", name, k);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by time limit expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int st;
        int cnt;
        int w0;
        int t0;
        bus.i_scyc  = 1'b0;
        bus.i_sstb  = 1'b0;
        bus.i_swe   = 1'b0;
        bus.i_saddr = '0;
        bus.i_sdata = '0;
        bus.i_ssel  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 64'(bus.dbg_state), 64'd0);
        check("rst_mcyc", 64'(bus.o_mcyc), 64'd0);
        check("rst_sack", 64'(bus.o_sack), 64'd0);
        check("rst_werr", 64'(bus.o_werr), 64'd0);
        check("rst_sdata", 64'(bus.o_sdata), 64'd0);
        check("rst_stall", 64'(bus.o_sstall), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Merge two half-word writes to address 5, then let the timer flush them.
        push_s(1'b0, 1'b0, '0);
        push_s(1'b0, 1'b0, '0);
        push_m(1'b1, 13'd5, 64'h0506_0708_0102_0304, 8'hFF);
        wb_req(1'b1, 13'd5, 64'hAAAA_AAAA_0102_0304, 8'h0F, st);
        wb_req(1'b1, 13'd5, 64'h0506_0708_BBBB_BBBB, 8'hF0, st);
        check("merge_no_stall", 64'(st), 64'd0);
        wb_idle();
        cnt = 0;
        while (!bus.o_mstb && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        total++;
`ifdef WBWCOMBINE_FULLFLUSH_EN
        if (cnt > 2) begin
`else
        if (cnt < TIMEOUT || cnt > TIMEOUT + 1) begin
`endif
            bad++;
            $display("FAIL flush_latency: got %0d cycles expected timeout window", cnt);
        end
        wait_idle("merge_done", 60);

        // Different address while holding: stall, flush 5, then hold 6.
        push_s(1'b0, 1'b0, '0);
        push_s(1'b0, 1'b0, '0);
        push_m(1'b1, 13'd5, 64'h11, 8'h01);
        push_m(1'b1, 13'd6, 64'h2200, 8'h02);
        wb_req(1'b1, 13'd5, 64'h11, 8'h01, st);
        wb_req(1'b1, 13'd6, 64'h2200, 8'h02, st);
        total++;
        if (st == 0) begin
            bad++;
            $display("FAIL mismatch_stall: got %0d stall cycles expected at least 1", st);
        end
        #1;
        check("mismatch_hold6", 64'(bus.dbg_state), 64'd1);
        wb_release();
        wait_idle("mismatch_done", 60);

        // Write then read the same address: write must reach downstream first.
        push_s(1'b0, 1'b0, '0);
        push_s(1'b1, 1'b0, 64'hDA7A_0000_0000_0009);
        push_m(1'b1, 13'd9, 64'h0000_A5A5_A5A5_0000, 8'h3C);
        push_m(1'b0, 13'd9, '0, '0);
        wb_req(1'b1, 13'd9, 64'h0000_A5A5_A5A5_0000, 8'h3C, st);
        wb_req(1'b0, 13'd9, '0, 8'hFF, st);
        wb_idle();
        wait_idle("order_done", 60);
        wb_release();

        // Failed flush: one-cycle write error pulse, no upstream error.
        w0 = werr_pulses;
        werr_maxrun = 0;
        err_cfg = 1'b1;
        push_s(1'b0, 1'b0, '0);
        push_m(1'b1, 13'h20, 64'h77, 8'h01);
        wb_req(1'b1, 13'h20, 64'h77, 8'h01, st);
        wb_release();
        wait_idle("werr_done", 60);
        repeat (2) @(posedge clk);
        #1;
        check("werr_pulses", 64'(werr_pulses - w0), 64'd1);
        check("werr_width", 64'(werr_maxrun), 64'd1);
        check("werr_state", 64'(bus.dbg_state), 64'd0);

        // Failed read: upstream error.
        err_cfg = 1'b1;
        push_s(1'b1, 1'b1, '0);
        push_m(1'b0, 13'd3, '0, '0);
        wb_req(1'b0, 13'd3, '0, 8'hFF, st);
        wb_idle();
        wait_idle("rderr_done", 60);
        wb_release();

        // Cycle drop during a stalled read: downstream cycle drops next cycle, no ack.
        stall_cfg = 50;
        wb_req(1'b0, 13'd7, '0, 8'hFF, st);
        wb_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rd_mcyc_before_drop", 64'(bus.o_mcyc), 64'd1);
        wb_release();
        @(posedge clk);
        #1;
        check("rd_drop_mcyc", 64'(bus.o_mcyc), 64'd0);
        check("rd_drop_state", 64'(bus.dbg_state), 64'd0);
        repeat (4) @(posedge clk);
        stall_cfg = 0;

        // Reset in the middle of a flush discards the buffer.
        stall_cfg = 50;
        push_s(1'b0, 1'b0, '0);
        wb_req(1'b1, 13'h30, 64'h99, 8'h01, st);
        wb_release();
        cnt = 0;
        while (!bus.o_mcyc && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("rstflush_started", 64'(bus.o_mcyc), 64'd1);
        t0 = m_txn;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstflush_mcyc", 64'(bus.o_mcyc), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        stall_cfg = 0;
        repeat (20) @(posedge clk);
        #1;
        check("rstflush_discard", 64'(m_txn - t0), 64'd0);
        check("rstflush_state", 64'(bus.dbg_state), 64'd0);

        check("exp_s_empty", 64'(exp_s_q.size()), 64'd0);
        check("exp_m_empty", 64'(exp_m_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
